vec_issue_stage: RTL and testbench

Decode-to-execute pipeline register and vector beat sequencer for the vector CPU. It receives the stall and flush requests from the hazard logic and turns them into E-stage register behaviour: hold, bubble or load. It breaks each vector instruction into ceil(vlen/LANES) execute beats. While a multi-beat op is in flight, it back-pressures fetch and decode with `busy`.

---
 rtl/vec_pipe_pkg.sv | 44 ++++
 rtl/vec_beat_seq.sv | 72 +++++++
 rtl/vec_issue_stage.sv | 174 +++++++++++++++++
 tb/tb_vec_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pipe_pkg.sv
// Shared types and constants for the vector issue stage.
//
// Contents:
//   LANES_DEF, MAX_VLEN_DEF : default lane count and maximum vector length
//   REG_ADDR_W              : register address width
//   e_state_t               : E-stage occupancy state (IDLE, RUN, SEQ)
//   e_fields_t              : address/control fields held in the E register
//   num_beats()             : beats needed for a vector length, never less than 1
package vec_pipe_pkg;

  localparam int LANES_DEF    = 4;
  localparam int MAX_VLEN_DEF = 16;
  localparam int REG_ADDR_W   = 4;

  // IDLE: E is empty or holds a bubble.
  // RUN : E holds the final (or only) beat of an instruction.
  // SEQ : E holds a beat and at least one more beat is pending.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEQ  = 2'd2
  } e_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [REG_ADDR_W-1:0] wa3;
    logic                  reg_write;
    logic                  mem_to_reg;
  } e_fields_t;

  // A zero-length vector still occupies one beat with every lane masked off.
  function automatic int unsigned num_beats(input int unsigned vlen,
                                            input int unsigned lanes);
    int unsigned nb;
    if (vlen == 0) begin
      nb = 1;
    end else begin
      nb = (vlen + lanes - 1) / lanes;
    end
    return nb;
  endfunction

endpackage

// File: rtl/vec_beat_seq.sv
// Beat sequencer for the vector issue stage.
//
// Holds the beat counter and the element count of the instruction in E,
// and derives the lane mask and last-beat flag from those registers.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   load           : capture vlen_in and restart at beat 0
//   advance        : step to the next beat of the held instruction
//   clear          : bubble; element count and beat return to 0
//   vlen_in        : element count of the instruction being loaded
//   beat           : current beat index
//   lane_mask      : lanes active on the current beat
//   last_beat      : current beat is the final one of the held instruction
//   next_last      : the beat after the current one will be the final one
//   in_single_beat : the instruction on vlen_in needs only one beat
module vec_beat_seq
  import vec_pipe_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int MAX_VLEN = MAX_VLEN_DEF,
  parameter int VL_W     = $clog2(MAX_VLEN + 1),
  parameter int BEAT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic              clear,
  input  logic [VL_W-1:0]   vlen_in,
  output logic [BEAT_W-1:0] beat,
  output logic [LANES-1:0]  lane_mask,
  output logic              last_beat,
  output logic              next_last,
  output logic              in_single_beat
);

  logic [BEAT_W-1:0] beat_reg;
  logic [VL_W-1:0]   vlen_reg;
  int unsigned       nb_held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_reg <= '0;
      vlen_reg <= '0;
    end else if (advance) begin
      beat_reg <= beat_reg + BEAT_W'(1);
    end else if (load) begin
      beat_reg <= '0;
      vlen_reg <= vlen_in;
    end else if (clear) begin
      // A cleared element count makes the bubble's lane mask all zeros.
      beat_reg <= '0;
      vlen_reg <= '0;
    end
  end

  assign nb_held        = num_beats(32'(vlen_reg), unsigned'(LANES));
  assign last_beat      = (32'(beat_reg) + 32'd1) == nb_held;
  assign next_last      = (32'(beat_reg) + 32'd2) == nb_held;
  assign in_single_beat = num_beats(32'(vlen_in), unsigned'(LANES)) == 32'd1;
  assign beat           = beat_reg;

  // Lane gi covers element beat*LANES + gi of the vector.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_mask[gi] =
        (32'(beat_reg) * unsigned'(LANES) + unsigned'(gi)) < 32'(vlen_reg);
    end
  endgenerate

endmodule

// File: rtl/vec_issue_stage.sv
// Decode-to-execute pipeline register and vector beat sequencer.
//
// Turns hazard stall/flush requests into E-register hold/bubble/load
// behaviour and splits each vector instruction into ceil(vlen/LANES)
// execute beats, holding the front end with busy while beats remain.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   valid_d                    : decode holds an instruction
//   ra1_d, ra2_d, wa3_d        : decode register addresses
//   reg_write_d, mem_to_reg_d  : decode control bits
//   is_vec_d, vlen_d           : vector flag and element count
//   stall_d, flush_e           : hazard requests (both bubble E)
//   valid_e                    : E holds a live beat
//   ra1_e, ra2_e, wa3_e        : E register addresses
//   reg_write_e, mem_to_reg_e  : E controls, zero in bubbles
//   beat_e, lane_mask_e        : current beat index and active lanes
//   last_beat_e                : current beat is final (1 in bubbles)
//   busy                       : more beats pending; front end must hold
//
// Optional feature (macro VEC_ISSUE_STATS_EN): saturating 32-bit counters
//   stat_issued, stat_bubbles, stat_seq_cycles.
module vec_issue_stage
  import vec_pipe_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int MAX_VLEN = MAX_VLEN_DEF,
  parameter int VL_W     = $clog2(MAX_VLEN + 1),
  parameter int BEAT_W   = (((MAX_VLEN + LANES - 1) / LANES) > 1) ?
                           $clog2((MAX_VLEN + LANES - 1) / LANES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] ra1_d,
  input  logic [REG_ADDR_W-1:0] ra2_d,
  input  logic [REG_ADDR_W-1:0] wa3_d,
  input  logic                  reg_write_d,
  input  logic                  mem_to_reg_d,
  input  logic                  is_vec_d,
  input  logic [VL_W-1:0]       vlen_d,
  input  logic                  stall_d,
  input  logic                  flush_e,
  output logic                  valid_e,
  output logic [REG_ADDR_W-1:0] ra1_e,
  output logic [REG_ADDR_W-1:0] ra2_e,
  output logic [REG_ADDR_W-1:0] wa3_e,
  output logic                  reg_write_e,
  output logic                  mem_to_reg_e,
  output logic [BEAT_W-1:0]     beat_e,
  output logic [LANES-1:0]      lane_mask_e,
  output logic                  last_beat_e,
  output logic                  busy
`ifdef VEC_ISSUE_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_bubbles,
  output logic [31:0]           stat_seq_cycles
`endif
);

  e_state_t        state_reg, state_next;
  e_fields_t       e_reg, e_next;
  logic            seq_load, seq_adv, seq_clr, hz_bubble;
  logic            seq_last, seq_next_last, seq_in_single;
  logic [VL_W-1:0] vlen_sat, vlen_in;

  assign vlen_sat = (vlen_d > VL_W'(MAX_VLEN)) ? VL_W'(MAX_VLEN) : vlen_d;
  // A scalar behaves like a one-element vector: one beat, lane 0 only.
  assign vlen_in  = is_vec_d ? vlen_sat : VL_W'(1);

  vec_beat_seq #(
    .LANES    (LANES),
    .MAX_VLEN (MAX_VLEN),
    .VL_W     (VL_W),
    .BEAT_W   (BEAT_W)
  ) u_beat_seq (
    .clk            (clk),
    .reset          (reset),
    .load           (seq_load),
    .advance        (seq_adv),
    .clear          (seq_clr),
    .vlen_in        (vlen_in),
    .beat           (beat_e),
    .lane_mask      (lane_mask_e),
    .last_beat      (seq_last),
    .next_last      (seq_next_last),
    .in_single_beat (seq_in_single)
  );

  // Priority: pending beats > flush/stall bubble > load/empty bubble.
  always_comb begin
    state_next = state_reg;
    e_next     = e_reg;
    seq_load   = 1'b0;
    seq_adv    = 1'b0;
    seq_clr    = 1'b0;
    hz_bubble  = 1'b0;
    if (state_reg == SEQ) begin
      // Hazard requests seen here are dropped, not queued.
      seq_adv    = 1'b1;
      state_next = seq_next_last ? RUN : SEQ;
    end else if (flush_e || stall_d) begin
      hz_bubble  = 1'b1;
      seq_clr    = 1'b1;
      e_next     = '0;
      state_next = IDLE;
    end else if (valid_d) begin
      seq_load          = 1'b1;
      e_next.ra1        = ra1_d;
      e_next.ra2        = ra2_d;
      e_next.wa3        = wa3_d;
      e_next.reg_write  = reg_write_d;
      e_next.mem_to_reg = mem_to_reg_d;
      state_next        = seq_in_single ? RUN : SEQ;
    end else begin
      seq_clr    = 1'b1;
      e_next     = '0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_reg <= '0;
    end else begin
      e_reg <= e_next;
    end
  end

  assign valid_e      = (state_reg != IDLE);
  assign ra1_e        = e_reg.ra1;
  assign ra2_e        = e_reg.ra2;
  assign wa3_e        = e_reg.wa3;
  assign reg_write_e  = e_reg.reg_write;
  assign mem_to_reg_e = e_reg.mem_to_reg;
  assign last_beat_e  = valid_e ? seq_last : 1'b1;
  assign busy         = valid_e && !last_beat_e;

`ifdef VEC_ISSUE_STATS_EN
  logic [31:0] stat_issued_reg, stat_bubbles_reg, stat_seq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_reg  <= '0;
      stat_bubbles_reg <= '0;
      stat_seq_reg     <= '0;
    end else begin
      if (seq_load && stat_issued_reg != '1) begin
        stat_issued_reg <= stat_issued_reg + 32'd1;
      end
      if (hz_bubble && stat_bubbles_reg != '1) begin
        stat_bubbles_reg <= stat_bubbles_reg + 32'd1;
      end
      if (busy && stat_seq_reg != '1) begin
        stat_seq_reg <= stat_seq_reg + 32'd1;
      end
    end
  end

  assign stat_issued     = stat_issued_reg;
  assign stat_bubbles    = stat_bubbles_reg;
  assign stat_seq_cycles = stat_seq_reg;
`endif

endmodule

// File: tb/tb_vec_issue_stage.sv
// Self-checking bench for vec_issue_stage: directed scenarios followed by
// randomized traffic, checked against a beat-list reference model.
module tb_vec_issue_stage;

  localparam int LANES    = 4;
  localparam int MAX_VLEN = 16;
  localparam int VL_W     = 5;
  localparam int BEAT_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_d, reg_write_d, mem_to_reg_d, is_vec_d;
  logic [3:0]        ra1_d, ra2_d, wa3_d;
  logic [VL_W-1:0]   vlen_d;
  logic              stall_d, flush_e;
  logic              valid_e, reg_write_e, mem_to_reg_e, last_beat_e, busy;
  logic [3:0]        ra1_e, ra2_e, wa3_e;
  logic [BEAT_W-1:0] beat_e;
  logic [LANES-1:0]  lane_mask_e;
`ifdef VEC_ISSUE_STATS_EN
  logic [31:0]       stat_issued, stat_bubbles, stat_seq_cycles;
`endif

  always #5 clk = ~clk;

  vec_issue_stage #(.LANES(LANES), .MAX_VLEN(MAX_VLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_d      (valid_d),
    .ra1_d        (ra1_d),
    .ra2_d        (ra2_d),
    .wa3_d        (wa3_d),
    .reg_write_d  (reg_write_d),
    .mem_to_reg_d (mem_to_reg_d),
    .is_vec_d     (is_vec_d),
    .vlen_d       (vlen_d),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .valid_e      (valid_e),
    .ra1_e        (ra1_e),
    .ra2_e        (ra2_e),
    .wa3_e        (wa3_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .beat_e       (beat_e),
    .lane_mask_e  (lane_mask_e),
    .last_beat_e  (last_beat_e),
    .busy         (busy)
`ifdef VEC_ISSUE_STATS_EN
    ,
    .stat_issued     (stat_issued),
    .stat_bubbles    (stat_bubbles),
    .stat_seq_cycles (stat_seq_cycles)
`endif
  );

  // Reference model: the instruction in E is a list of beat records;
  // cur is the beat in E and pend holds the beats still to come.
  typedef struct packed {
    logic [3:0]        ra1, ra2, wa3;
    logic              rw, mtr;
    logic [BEAT_W-1:0] beat;
    logic [LANES-1:0]  mask;
  } beat_t;

  beat_t pend[$];
  beat_t cur = '0;
  bit    cur_valid = 1'b0;
  int    exp_issued = 0, exp_bubbles = 0, exp_seq = 0;
  int    n_vec = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_load();
    int    v, nb;
    beat_t b;
    v  = (int'(vlen_d) > MAX_VLEN) ? MAX_VLEN : int'(vlen_d);
    nb = !is_vec_d ? 1 : (v == 0 ? 1 : (v + LANES - 1) / LANES);
    pend.delete();
    for (int k = 0; k < nb; k++) begin
      b      = '0;
      b.ra1  = ra1_d;
      b.ra2  = ra2_d;
      b.wa3  = wa3_d;
      b.rw   = reg_write_d;
      b.mtr  = mem_to_reg_d;
      b.beat = BEAT_W'(k);
      for (int i = 0; i < LANES; i++) begin
        b.mask[i] = is_vec_d ? ((k * LANES + i) < v) : (i == 0);
      end
      pend.push_back(b);
    end
    cur       = pend.pop_front();
    cur_valid = 1'b1;
    exp_issued++;
  endtask

  task automatic model_reset();
    cur_valid   = 1'b0;
    cur         = '0;
    pend.delete();
    exp_issued  = 0;
    exp_bubbles = 0;
    exp_seq     = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (cur_valid && pend.size() != 0) begin
      exp_seq++;
      cur = pend.pop_front();
    end else if (flush_e || stall_d) begin
      exp_bubbles++;
      cur_valid = 1'b0;
      cur       = '0;
    end else if (!valid_d) begin
      cur_valid = 1'b0;
      cur       = '0;
    end else begin
      model_load();
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_busy;
    exp_busy = cur_valid && (pend.size() != 0);
    check_val({tag, ".valid"}, 32'(valid_e), 32'(cur_valid));
    check_val({tag, ".ra1"},   32'(ra1_e), 32'(cur.ra1));
    check_val({tag, ".ra2"},   32'(ra2_e), 32'(cur.ra2));
    check_val({tag, ".wa3"},   32'(wa3_e), 32'(cur.wa3));
    check_val({tag, ".rw"},    32'(reg_write_e), 32'(cur.rw));
    check_val({tag, ".mtr"},   32'(mem_to_reg_e), 32'(cur.mtr));
    check_val({tag, ".beat"},  32'(beat_e), 32'(cur.beat));
    check_val({tag, ".mask"},  32'(lane_mask_e), 32'(cur.mask));
    check_val({tag, ".last"},  32'(last_beat_e), 32'(!exp_busy));
    check_val({tag, ".busy"},  32'(busy), 32'(exp_busy));
`ifdef VEC_ISSUE_STATS_EN
    check_val({tag, ".st_iss"}, stat_issued, 32'(exp_issued));
    check_val({tag, ".st_bub"}, stat_bubbles, 32'(exp_bubbles));
    check_val({tag, ".st_seq"}, stat_seq_cycles, 32'(exp_seq));
`endif
  endtask

  // Inputs are stable across the edge; outputs are sampled 1 ns after it.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    $display("cyc %s: valid_e=%0b wa3_e=%0d beat_e=%0d mask=%b last=%0b busy=%0b",
             tag, valid_e, wa3_e, beat_e, lane_mask_e, last_beat_e, busy);
  endtask

  task automatic set_instr(input logic v, input logic vec, input int vl,
                           input logic [3:0] wa);
    valid_d      = v;
    is_vec_d     = vec;
    vlen_d       = VL_W'(vl);
    wa3_d        = wa;
    ra1_d        = wa + 4'd1;
    ra2_d        = wa + 4'd2;
    reg_write_d  = 1'b1;
    mem_to_reg_d = wa[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_instr(1'b0, 1'b0, 0, 4'd0);
    reg_write_d = 1'b0;
    stall_d = 1'b0;
    flush_e = 1'b0;
    #2;
    check_all("reset");
    tick("reset_hold");
    reset = 1'b0;

    // Scalar load.
    set_instr(1'b1, 1'b0, 0, 4'd5);
    tick("scalar");
    check_val("scalar_wa3", 32'(wa3_e), 32'd5);
    check_val("scalar_mask", 32'(lane_mask_e), 32'h1);

    // Vector vlen=10: three beats, next instruction on the fourth cycle.
    set_instr(1'b1, 1'b1, 10, 4'd7);
    tick("v10_b0");
    check_val("v10_b0_mask", 32'(lane_mask_e), 32'hf);
    set_instr(1'b1, 1'b0, 0, 4'd9);
    tick("v10_b1");
    tick("v10_b2");
    check_val("v10_b2_mask", 32'(lane_mask_e), 32'h3);
    tick("v10_next");
    check_val("v10_next_wa3", 32'(wa3_e), 32'd9);

    // Load-use: bubble, then the same instruction loads.
    set_instr(1'b1, 1'b0, 0, 4'd6);
    stall_d = 1'b1;
    flush_e = 1'b1;
    tick("loaduse_bub");
    check_val("loaduse_valid", 32'(valid_e), 32'd0);
    stall_d = 1'b0;
    flush_e = 1'b0;
    tick("loaduse_load");
    check_val("loaduse_wa3", 32'(wa3_e), 32'd6);

    // Flush while beat 1 of 3 is in E is ignored.
    set_instr(1'b1, 1'b1, 10, 4'd3);
    tick("fl_b0");
    set_instr(1'b0, 1'b0, 0, 4'd0);
    tick("fl_b1");
    flush_e = 1'b1;
    tick("fl_b2");
    check_val("fl_b2_beat", 32'(beat_e), 32'd2);
    check_val("fl_b2_mask", 32'(lane_mask_e), 32'h3);
    tick("fl_bub");
    flush_e = 1'b0;

    // Reset asserted during beat 1 of a 4-beat op.
    set_instr(1'b1, 1'b1, 16, 4'd11);
    tick("rst_b0");
    set_instr(1'b0, 1'b0, 0, 4'd0);
    tick("rst_b1");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    tick("rst_hold");
    reset = 1'b0;
    tick("rst_after");

    // vlen=0: one beat, no lanes.
    set_instr(1'b1, 1'b1, 0, 4'd2);
    tick("vl0");
    check_val("vl0_mask", 32'(lane_mask_e), 32'h0);
    check_val("vl0_busy", 32'(busy), 32'd0);

    // vlen=20 saturates to 16: four full beats.
    set_instr(1'b1, 1'b1, 20, 4'd4);
    tick("vl20_b0");
    set_instr(1'b0, 1'b0, 0, 4'd0);
    tick("vl20_b1");
    tick("vl20_b2");
    tick("vl20_b3");
    check_val("vl20_b3_beat", 32'(beat_e), 32'd3);
    check_val("vl20_b3_mask", 32'(lane_mask_e), 32'hf);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      valid_d      = ($urandom_range(0, 3) != 0);
      is_vec_d     = ($urandom_range(0, 9) < 7);
      vlen_d       = VL_W'($urandom_range(0, 20));
      ra1_d        = 4'($urandom);
      ra2_d        = 4'($urandom);
      wa3_d        = 4'($urandom);
      reg_write_d  = 1'($urandom);
      mem_to_reg_d = 1'($urandom);
      stall_d      = ($urandom_range(0, 99) < 15);
      flush_e      = ($urandom_range(0, 99) < 10);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
